stopwatch_core: RTL

//  MM:SS stopwatch with count, pause and adjust modes driving a 4-digit

---
 rtl/stopwatch_core.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: free-running tick dividers, BCD time registers with count/adjust
// modes, blink of the field under adjustment and a registered 4-digit display scan.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_COUNT  | sec ticks advance the time while running
// ST_ADJUST | adj ticks step the selected field, sec ticks ignored
module stopwatch_core #(
    parameter int unsigned SEC_DIV   = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned MAX_MIN   = 59
) (
    input  logic       clk,
    input  logic       resett,
    input  logic       pause,
    input  logic       select,
    input  logic [1:0] adj,
    output logic [6:0] seven_seg_display,
    output logic [3:0] an
);

    localparam logic [0:0] ST_COUNT  = 1'b0;
    localparam logic [0:0] ST_ADJUST = 1'b1;

    localparam int unsigned SEC_W   = (SEC_DIV > 1)   ? $clog2(SEC_DIV)   : 1;
    localparam int unsigned ADJ_W   = (ADJ_DIV > 1)   ? $clog2(ADJ_DIV)   : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               sec_tick, adj_tick, blink_tick, scan_tick;

    logic [0:0] state_q, state_d;
    logic       sel_q, dir_q;
    logic       pause_q, pause_prev_q, pause_rise;
    logic       running_q, running_d;
    logic       blink_q, blink_d;
    logic [1:0] scan_idx_q, scan_idx_d;

    logic [3:0] sec_o_q, sec_t_q, min_o_q, min_t_q;
    logic [3:0] sec_o_d, sec_t_d, min_o_d, min_t_d;

    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] digit;
    logic       slot_is_sec;
    logic       blank;

    // Wraps to 00 once the limit is reached, so values never leave the field range.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] lt, input logic [3:0] lo);
        logic [7:0] r;
        if (t == lt && o == lo)  r = 8'h00;
        else if (o == 4'd9)      r = {t + 4'd1, 4'd0};
        else                     r = {t, o + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] lt, input logic [3:0] lo);
        logic [7:0] r;
        if (t == 4'd0 && o == 4'd0)  r = {lt, lo};
        else if (o == 4'd0)          r = {t - 4'd1, 4'd9};
        else                         r = {t, o - 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign sec_tick   = (sec_cnt_q   == SEC_W'(SEC_DIV - 1));
    assign adj_tick   = (adj_cnt_q   == ADJ_W'(ADJ_DIV - 1));
    assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign scan_tick  = (scan_cnt_q  == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        sec_cnt_d   = sec_tick   ? '0 : sec_cnt_q   + 1'b1;
        adj_cnt_d   = adj_tick   ? '0 : adj_cnt_q   + 1'b1;
        blink_cnt_d = blink_tick ? '0 : blink_cnt_q + 1'b1;
        scan_cnt_d  = scan_tick  ? '0 : scan_cnt_q  + 1'b1;
    end

    // A tick landing on the same clock as a pause edge still sees the old running flag.
    assign pause_rise = pause_q & ~pause_prev_q;

    always_comb begin
        state_d    = adj[0] ? ST_ADJUST : ST_COUNT;
        running_d  = running_q ^ pause_rise;
        blink_d    = blink_q ^ blink_tick;
        scan_idx_d = scan_idx_q;
        if (scan_tick) scan_idx_d = scan_idx_q + 2'd1;
    end

    always_comb begin
        {sec_t_d, sec_o_d} = {sec_t_q, sec_o_q};
        {min_t_d, min_o_d} = {min_t_q, min_o_q};
        if (state_q == ST_COUNT) begin
            if (sec_tick && running_q) begin
                {sec_t_d, sec_o_d} = bcd_inc(sec_t_q, sec_o_q, 4'd5, 4'd9);
                if (sec_t_q == 4'd5 && sec_o_q == 4'd9)
                    {min_t_d, min_o_d} = bcd_inc(min_t_q, min_o_q, MAX_T, MAX_O);
            end
        end else if (adj_tick) begin
            if (sel_q)
                {sec_t_d, sec_o_d} = dir_q ? bcd_dec(sec_t_q, sec_o_q, 4'd5, 4'd9)
                                           : bcd_inc(sec_t_q, sec_o_q, 4'd5, 4'd9);
            else
                {min_t_d, min_o_d} = dir_q ? bcd_dec(min_t_q, min_o_q, MAX_T, MAX_O)
                                           : bcd_inc(min_t_q, min_o_q, MAX_T, MAX_O);
        end
    end

    always_comb begin
        digit       = sec_o_q;
        an_d        = 4'b1110;
        slot_is_sec = 1'b1;
        case (scan_idx_q)
            2'd0: begin digit = sec_o_q; an_d = 4'b1110; slot_is_sec = 1'b1; end
            2'd1: begin digit = sec_t_q; an_d = 4'b1101; slot_is_sec = 1'b1; end
            2'd2: begin digit = min_o_q; an_d = 4'b1011; slot_is_sec = 1'b0; end
            default: begin digit = min_t_q; an_d = 4'b0111; slot_is_sec = 1'b0; end
        endcase
        // Anode keeps strobing a blanked digit so the scan timing never changes.
        blank = (state_q == ST_ADJUST) && blink_q && (slot_is_sec == sel_q);
        seg_d = blank ? 7'h7F : seg_decode(digit);
    end

    always_ff @(posedge clk or posedge resett) begin
        if (resett) begin
            sec_cnt_q    <= '0;
            adj_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            scan_cnt_q   <= '0;
            state_q      <= ST_COUNT;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
            running_q    <= 1'b1;
            blink_q      <= 1'b0;
            scan_idx_q   <= 2'd0;
            sec_o_q      <= 4'd0;
            sec_t_q      <= 4'd0;
            min_o_q      <= 4'd0;
            min_t_q      <= 4'd0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
        end else begin
            sec_cnt_q    <= sec_cnt_d;
            adj_cnt_q    <= adj_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            state_q      <= state_d;
            sel_q        <= select;
            dir_q        <= adj[1];
            pause_q      <= pause;
            pause_prev_q <= pause_q;
            running_q    <= running_d;
            blink_q      <= blink_d;
            scan_idx_q   <= scan_idx_d;
            sec_o_q      <= sec_o_d;
            sec_t_q      <= sec_t_d;
            min_o_q      <= min_o_d;
            min_t_q      <= min_t_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign seven_seg_display = seg_q;
    assign an                = an_q;

endmodule
